// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register.
// SKID=0 holds one entry; SKID=1 is a two-entry skid buffer.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter bit               SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKIDF = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;

  // Skid mode exposes a registered ready; single mode passes out_ready through.
  assign in_ready = ~reset &
    (SKID ? rdy_q : (out_ready | ~out_valid));

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and data-path selection; flush overrides everything.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = FULL;
          main_d  = in_data;
        end
      end
      FULL: begin
        unique case (1'b1)
          in_fire && out_fire: begin
            main_d = in_data;
          end
          in_fire && !out_fire && SKID: begin
            state_d = SKIDF;
            skid_d  = in_data;
          end
          !in_fire && out_fire: begin
            state_d = EMPTY;
          end
          default: ;
        endcase
      end
      SKIDF: begin
        if (out_fire) begin
          state_d = FULL;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    rdy_d = (state_d != SKIDF);
  end

  // State, storage and registered ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= INIT;
      skid_q  <= INIT;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

  a_count_bound: assert property (
    @(posedge clk) disable iff (reset)
    !(!SKID && count == 2'd2));

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register for the NPC datapath. It generalises a plain enable register into a valid/ready handshaked stage, so IF/ID/EX/LS/WB boundaries can stall and flush without losing data.
- Two modes:
  - Mode 0: single-entry register with a combinational ready path.
  - Mode 1: two-entry skid buffer. Ready is registered and throughput is full.

Parameters:
- WIDTH, 32: payload width in bits; legal range 1..256.
- INIT, 0: reset value of all data storage and of out_data.
- SKID, 1: 0 = single-entry mode; 1 = skid-buffer mode.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clock clk.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  payload of the oldest entry.
- count  output  2  entries held: 0..2; never exceeds 1 when SKID=0.

Behaviour:
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Both are sampled at the rising edge of clk.
- Reset (asynchronous):
  - State goes to EMPTY; out_valid=0; count=0.
  - Main and skid registers load INIT; out_data=INIT.
  - in_ready is forced 0 while reset is high and returns to 1 in the first cycle after release.
- Latency: an entry accepted in cycle N appears on out_valid/out_data in cycle N+1. There is no combinational in_data-to-out_data path in either mode.
- Ordering and stability:
  - Strict FIFO order.
  - While out_valid=1 and out_ready=0, out_data and out_valid must hold stable.
- States:
  - EMPTY (count 0).
  - FULL (count 1; main register valid).
  - SKID (count 2; main and skid registers valid; exists only when SKID=1).
- SKID=0:
  - in_ready = out_ready | ~out_valid, combinational.
  - EMPTY + in_fire -> FULL; main <= in_data.
  - FULL + out_fire + in_fire -> FULL; main <= in_data (back-to-back, no bubble).
  - FULL + out_fire only -> EMPTY.
  - Otherwise, hold.
- SKID=1:
  - in_ready is a register output: 1 in EMPTY and FULL, 0 in SKID. It must not depend combinationally on out_ready.
  - EMPTY + in_fire -> FULL; main <= in_data.
  - FULL + in_fire + out_fire -> FULL; main <= in_data.
  - FULL + in_fire + no out_fire -> SKID; skid <= in_data; main is unchanged.
  - FULL + out_fire only -> EMPTY.
  - SKID + out_fire -> FULL; main <= skid. in_fire is impossible in SKID.
  - SKID + no out_fire -> hold.
- Flush (highest priority after reset):
  - Next state is EMPTY and count=0.
  - Any in_fire in the flush cycle is discarded: nothing is written and upstream treats it as squashed.
  - A simultaneous out_fire still counts as consumed downstream.
  - Data registers are not cleared; out_data is don't-care while out_valid=0.
  - The cycle after flush: out_valid=0, in_ready=1.
- Boundaries:
  - in_valid with in_ready=0 is a stall: no write occurs; upstream must hold data.
  - Reset asserted mid-transfer drops all entries immediately; no partial state survives.
  - The count encoding never wraps. count=2 with SKID=0 is an assertion failure.
  - out_valid == (count != 0) at all times.

Test Plan:
- Reset mid-stream: INIT=32'hDEADBEEF, assert reset while FULL -> same-cycle out_valid=0, out_data=32'hDEADBEEF, count=0, in_ready=0; after release in_ready=1.
- Streaming, both modes: out_ready=1, send 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on cycles N+1..N+4 with out_valid continuous and no bubbles.
- Skid capture (SKID=1): send 10 then 11 with out_ready=0 -> count goes 1 then 2, in_ready=0, out_data=10 held. Raise out_ready -> 10 then 11 emerge; count goes 1 then 0.
- Single-entry stall (SKID=0): hold 5 with out_ready=0 -> in_ready=0 and 6 is not accepted; raise out_ready -> 5 and 6 transfer in the same cycle; 6 appears next cycle.
- Flush: in state SKID (entries 20, 21), assert flush with in_valid=1 and in_data=22 -> next cycle count=0, out_valid=0; 22 never appears at the output.
- Random stall soak: random in_valid/out_ready for 10k cycles in both modes -> output sequence equals the accepted input sequence; out_data stable during every stall; count bounded by mode.
